fetch4_unit: RTL

- 4-wide instruction fetch front end; sits directly upstream of the 4-port instruction SRAM.
- Generates four sequential word addresses per request and drives the SRAM read enables.
- Captures the SRAM read data one cycle later into a bundle FIFO, and presents bundles to decode with a valid/ready handshake.
- Supports a backend redirect (branch/exception) that flushes all queued and in-flight fetches.

---
 rtl/fetch4_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch4_unit.sv
// 4-wide instruction fetch front end: issues four sequential SRAM reads per request,
// queues the returned bundles and hands them to decode with a valid/ready handshake.
module fetch4_unit #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned             FQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redir_valid,
  input  logic [ADDR_WIDTH-1:0] redir_pc,
  output logic                  sram_en,
  output logic [ADDR_WIDTH-1:0] sram_raddr0,
  output logic [ADDR_WIDTH-1:0] sram_raddr1,
  output logic [ADDR_WIDTH-1:0] sram_raddr2,
  output logic [ADDR_WIDTH-1:0] sram_raddr3,
  input  logic [DATA_WIDTH-1:0] sram_rdata0,
  input  logic [DATA_WIDTH-1:0] sram_rdata1,
  input  logic [DATA_WIDTH-1:0] sram_rdata2,
  input  logic [DATA_WIDTH-1:0] sram_rdata3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst0,
  output logic [DATA_WIDTH-1:0] out_inst1,
  output logic [DATA_WIDTH-1:0] out_inst2,
  output logic [DATA_WIDTH-1:0] out_inst3
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      pc;
    logic [3:0][DATA_WIDTH-1:0] inst;
  } bundle_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  req_pending;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  bundle_t               fq [FQ_DEPTH];
  bundle_t               head;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        credit_used;

  // Credits cover both queued bundles and the one response that may still be in flight.
  always_comb begin
    credit_used = (CNT_W+1)'(count) + (CNT_W+1)'(req_pending);
    issue       = rst && !redir_valid && (credit_used < (CNT_W+1)'(FQ_DEPTH));
    push        = req_pending && !redir_valid;
    out_valid   = (count != '0) && !redir_valid;
    pop         = out_valid && out_ready;
  end

  assign sram_en     = issue;
  assign sram_raddr0 = pc;
  assign sram_raddr1 = pc + ADDR_WIDTH'(4);
  assign sram_raddr2 = pc + ADDR_WIDTH'(8);
  assign sram_raddr3 = pc + ADDR_WIDTH'(12);

  // Fetch pointer, in-flight tracking and FIFO bookkeeping; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      req_pending <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redir_valid) begin
      pc          <= redir_pc;
      req_pending <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      req_pending <= issue;
      if (issue) begin
        pc     <= pc + ADDR_WIDTH'(16);
        req_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Bundle storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fq[wr_ptr] <= '{pc: req_pc, inst: {sram_rdata3, sram_rdata2, sram_rdata1, sram_rdata0}};
    end
  end

  assign head      = fq[rd_ptr];
  assign out_pc    = head.pc;
  assign out_inst0 = head.inst[0];
  assign out_inst1 = head.inst[1];
  assign out_inst2 = head.inst[2];
  assign out_inst3 = head.inst[3];

endmodule
